// File: rtl/snps_pll_apb_sequencer.sv
// snps_pll_apb_sequencer: APB4 requester that programs, resets, lock-polls and enables the PLL after one start pulse
module snps_pll_apb_sequencer #(
  parameter int RST_CYCLES = 200,
  parameter int POLL_GAP   = 16,
  parameter int LOCK_POLLS = 64
) (
  input  logic        ref_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  cfg_fbdiv,
  input  logic [4:0]  cfg_prediv,
  input  logic [5:0]  cfg_p,
  input  logic [5:0]  cfg_r,
  input  logic [3:0]  cfg_divvcop,
  input  logic [3:0]  cfg_divvcor,
  input  logic        cfg_gear_shift,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [11:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  output logic [2:0]  PPROT,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);
  typedef enum logic [3:0] {
    S_IDLE, S_WR_DIV, S_WR_PRE, S_WR_PWR, S_RST_WAIT,
    S_WR_REL, S_POLL_GAP, S_RD_LOCK, S_WR_EN, S_FINISH
  } state_e;
  state_e state_q, state_d;
  logic en_q, en_d;
  logic [15:0] cnt_q, cnt_d, poll_q, poll_d;
  logic done_q, done_d, error_q, error_d;
  logic [1:0] code_q, code_d;
  logic [6:0] fbdiv_q;
  logic [4:0] prediv_q;
  logic [5:0] p_q, r_q;
  logic [3:0] vcop_q, vcor_q;
  logic gear_q;
  logic xfer, complete, accept;
  logic unused_prdata;
  assign unused_prdata = ^PRDATA[31:1];
  assign accept   = state_q == S_IDLE && start;
  assign xfer     = state_q inside {S_WR_DIV, S_WR_PRE, S_WR_PWR, S_WR_REL, S_RD_LOCK, S_WR_EN};
  assign complete = en_q && PREADY;
  // bus controls decode straight from state so an async reset drops PSEL at once
  assign PSEL     = xfer;
  assign PENABLE  = en_q;
  assign PWRITE   = xfer && state_q != S_RD_LOCK;
  assign PSTRB    = {4{PWRITE}};
  assign PPROT    = 3'b000;
  assign busy     = state_q != S_IDLE && state_q != S_FINISH;
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = code_q;
  always_comb begin
    PADDR  = 12'h000;
    PWDATA = 32'h0;
    case (state_q)
      S_WR_DIV: begin
        PADDR  = 12'h004;
        PWDATA = {4'b0, vcop_q, 2'b0, p_q, 4'b0, vcor_q, 2'b0, r_q};
      end
      S_WR_PRE: begin
        PADDR  = 12'h008;
        PWDATA = {19'b0, prediv_q, 1'b0, fbdiv_q};
      end
      S_WR_PWR:  PWDATA = {22'b0, 2'b01, gear_q, 7'b0};
      S_WR_REL:  PWDATA = {22'b0, 2'b11, gear_q, 7'b0};
      S_RD_LOCK: PADDR  = 12'h018;
      S_WR_EN:   PWDATA = 32'h0000_0330;
      default: ;
    endcase
  end
  always_comb begin
    state_d = state_q;
    en_d    = xfer && !complete;
    cnt_d   = cnt_q;
    poll_d  = poll_q;
    done_d  = done_q;
    error_d = error_q;
    code_d  = code_q;
    if (complete && PSLVERR) begin
      state_d = S_IDLE;
      error_d = 1'b1;
      code_d  = 2'b01;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d = S_WR_DIV;
          done_d  = 1'b0;
          error_d = 1'b0;
          code_d  = 2'b00;
          cnt_d   = '0;
          poll_d  = '0;
        end
        S_WR_DIV: if (complete) state_d = S_WR_PRE;
        S_WR_PRE: if (complete) state_d = S_WR_PWR;
        S_WR_PWR: if (complete) begin
          state_d = S_RST_WAIT;
          cnt_d   = '0;
        end
        S_RST_WAIT: begin
          cnt_d   = cnt_q + 16'd1;
          state_d = cnt_q == 16'(RST_CYCLES - 1) ? S_WR_REL : S_RST_WAIT;
        end
        S_WR_REL: if (complete) state_d = S_RD_LOCK;
        S_RD_LOCK: if (complete) begin
          if (PRDATA[0]) state_d = S_WR_EN;
          else if (poll_q == 16'(LOCK_POLLS - 1)) begin
            state_d = S_IDLE;
            error_d = 1'b1;
            code_d  = 2'b10;
          end else begin
            poll_d  = poll_q + 16'd1;
            cnt_d   = '0;
            state_d = POLL_GAP == 0 ? S_RD_LOCK : S_POLL_GAP;
          end
        end
        S_POLL_GAP: begin
          cnt_d   = cnt_q + 16'd1;
          state_d = cnt_q == 16'(POLL_GAP - 1) ? S_RD_LOCK : S_POLL_GAP;
        end
        S_WR_EN: if (complete) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      cnt_q    <= '0;
      poll_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= 2'b00;
      fbdiv_q  <= '0;
      prediv_q <= '0;
      p_q      <= '0;
      r_q      <= '0;
      vcop_q   <= '0;
      vcor_q   <= '0;
      gear_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
      if (accept) begin
        fbdiv_q  <= cfg_fbdiv;
        prediv_q <= cfg_prediv;
        p_q      <= cfg_p;
        r_q      <= cfg_r;
        vcop_q   <= cfg_divvcop;
        vcor_q   <= cfg_divvcor;
        gear_q   <= cfg_gear_shift;
      end
    end
  end
endmodule

// File: tb/tb_snps_pll_apb_sequencer.sv
// tb_snps_pll_apb_sequencer: directed bench with a scripted APB completer and transfer log
module tb_snps_pll_apb_sequencer;
  localparam int RC = 10, PG = 4, LP = 5;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [6:0] fbdiv = '0;
  logic [4:0] prediv = '0;
  logic [5:0] p = '0, r = '0;
  logic [3:0] vcop = '0, vcor = '0;
  logic gear = 1'b0;
  logic busy, done, error, psel, penable, pwrite, pready, pslverr;
  logic [1:0] err_code;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic [3:0] pstrb;
  logic [2:0] pprot;
  int lock_at = 1, acc = 0, rd_cnt = 0, cyc = 0;
  logic wait_pre = 1'b0, slv_pre = 1'b0;
  int errors = 0, checks = 0;
  logic [11:0] l_addr [128];
  logic [31:0] l_data [128];
  logic l_w [128];
  logic [3:0] l_strb [128];
  int tr_n = 0, r_n = 0, psel_cnt = 0, en8 = 0, stab_err = 0;
  int r_cyc [64];
  logic [11:0] la;
  logic [31:0] ld;
  logic lw;
  logic [3:0] ls;
  snps_pll_apb_sequencer #(.RST_CYCLES(RC), .POLL_GAP(PG), .LOCK_POLLS(LP)) dut (
    .ref_clk(clk), .reset(rst), .start(start),
    .cfg_fbdiv(fbdiv), .cfg_prediv(prediv), .cfg_p(p), .cfg_r(r),
    .cfg_divvcop(vcop), .cfg_divvcor(vcor), .cfg_gear_shift(gear),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );
  always #5 clk = ~clk;
  assign pready  = !(wait_pre && paddr == 12'h008) || acc >= 3;
  assign pslverr = slv_pre && paddr == 12'h008;
  assign prdata  = {31'b0, lock_at != 0 && rd_cnt + 1 >= lock_at};
  always @(posedge clk) begin
    cyc <= cyc + 1;
    acc <= (psel && penable && !pready) ? acc + 1 : 0;
    if (psel && !penable && paddr == 12'h004) rd_cnt <= 0;
    else if (psel && penable && pready && !pwrite) rd_cnt <= rd_cnt + 1;
  end
  always @(negedge clk) begin
    if (psel) psel_cnt++;
    if (psel && !penable) begin
      la = paddr; ld = pwdata; lw = pwrite; ls = pstrb;
      if (!pwrite && r_n < 64) begin r_cyc[r_n] = cyc; r_n++; end
    end
    if (psel && penable) begin
      if ({paddr, pwdata, pwrite, pstrb} !== {la, ld, lw, ls}) stab_err++;
      if (paddr == 12'h008) en8++;
      if (pready && tr_n < 128) begin
        l_addr[tr_n] = paddr; l_data[tr_n] = pwdata; l_w[tr_n] = pwrite; l_strb[tr_n] = pstrb;
        tr_n++;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_tr(input string tag, input int i, input logic [11:0] a, input logic [31:0] d, input logic w);
    chk(tag, {15'b0, l_w[i], l_strb[i], l_addr[i]}, {15'b0, w, {4{w}}, a});
    if (w) chk(tag, l_data[i], d);
  endtask
  task automatic run(input int poke, output int lat);
    int j;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("setup_div", {18'b0, psel, penable, paddr}, {18'b0, 1'b1, 1'b0, 12'h004});
    chk("start_flags", {29'b0, busy, done, error}, 32'b100);
    for (j = 1; j <= 400; j++) begin
      if (j == poke) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      if (done || error) break;
    end
    lat = j + 1;
  endtask
  initial begin
    int lat, b, rb, s;
    #1;
    chk("reset_outs", {busy, done, error, err_code, psel, penable, pwrite, pstrb, pprot, paddr}, 32'h0);
    chk("reset_wdata", pwdata, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // T1: lock on first read
    fbdiv = 7'h20; prediv = 5'h0; p = 6'd3; r = 6'd1; vcop = 4'h0; vcor = 4'h0; gear = 1'b1; lock_at = 1;
    b = tr_n;
    run(0, lat);
    chk("t1_latency", lat, 2 * 6 + RC + 1);
    chk("t1_flags", {busy, done, error, err_code}, 5'b01000);
    chk("t1_count", tr_n - b, 6);
    chk_tr("t1_div", b, 12'h004, 32'h0003_0001, 1'b1);
    chk_tr("t1_pre", b + 1, 12'h008, 32'h0000_0020, 1'b1);
    chk_tr("t1_pwr", b + 2, 12'h000, 32'h0000_0180, 1'b1);
    chk_tr("t1_rel", b + 3, 12'h000, 32'h0000_0380, 1'b1);
    chk_tr("t1_rd", b + 4, 12'h018, 32'h0, 1'b0);
    chk_tr("t1_en", b + 5, 12'h000, 32'h0000_0330, 1'b1);
    // T2: lock on third read, other field values
    fbdiv = 7'h7F; prediv = 5'h1F; p = 6'h3F; r = 6'h2A; vcop = 4'h5; vcor = 4'hA; gear = 1'b0; lock_at = 3;
    b = tr_n; rb = r_n;
    run(0, lat);
    chk("t2_latency", lat, 2 * 6 + RC + 2 * (2 + PG) + 1);
    chk("t2_flags", {busy, done, error, err_code}, 5'b01000);
    chk("t2_count", tr_n - b, 8);
    chk("t2_reads", r_n - rb, 3);
    chk("t2_gap1", r_cyc[rb + 1] - r_cyc[rb], 2 + PG);
    chk("t2_gap2", r_cyc[rb + 2] - r_cyc[rb + 1], 2 + PG);
    chk_tr("t2_div", b, 12'h004, 32'h053F_0A2A, 1'b1);
    chk_tr("t2_pre", b + 1, 12'h008, 32'h0000_1F7F, 1'b1);
    chk_tr("t2_pwr", b + 2, 12'h000, 32'h0000_0100, 1'b1);
    chk_tr("t2_rel", b + 3, 12'h000, 32'h0000_0300, 1'b1);
    chk_tr("t2_en", b + 7, 12'h000, 32'h0000_0330, 1'b1);
    // T3: lock never seen
    lock_at = 0;
    b = tr_n; rb = r_n;
    run(0, lat);
    chk("t3_latency", lat, 45);
    chk("t3_flags", {busy, done, error, err_code}, 5'b00110);
    chk("t3_reads", r_n - rb, LP);
    chk("t3_count", tr_n - b, 4 + LP);
    chk_tr("t3_last", tr_n - 1, 12'h018, 32'h0, 1'b0);
    // T4: PSLVERR on predivider write with three wait states
    lock_at = 1; wait_pre = 1'b1; slv_pre = 1'b1;
    b = tr_n; s = en8;
    run(0, lat);
    chk("t4_latency", lat, 8);
    chk("t4_flags", {busy, done, error, err_code}, 5'b00101);
    chk("t4_access", en8 - s, 4);
    chk("t4_count", tr_n - b, 2);
    s = psel_cnt;
    repeat (20) @(posedge clk);
    #1 chk("t4_no_psel", psel_cnt - s, 0);
    wait_pre = 1'b0; slv_pre = 1'b0;
    // T5: reset during RST_WAIT then restart
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("t5_async", {29'b0, psel, penable, busy}, 32'b0);
    @(posedge clk); #1 rst = 1'b0;
    b = tr_n;
    run(0, lat);
    chk("t5_latency", lat, 2 * 6 + RC + 1);
    chk("t5_flags", {busy, done, error, err_code}, 5'b01000);
    chk_tr("t5_div", b, 12'h004, 32'h053F_0A2A, 1'b1);
    // T6: start during poll loop ignored, start after done reruns
    lock_at = 3;
    b = tr_n;
    run(24, lat);
    chk("t6_latency", lat, 2 * 6 + RC + 2 * (2 + PG) + 1);
    chk("t6_count", tr_n - b, 8);
    b = tr_n;
    run(0, lat);
    chk("t6_rerun_latency", lat, 2 * 6 + RC + 2 * (2 + PG) + 1);
    chk("t6_rerun_count", tr_n - b, 8);
    chk("t6_flags", {busy, done, error, err_code}, 5'b01000);
    chk("stability", stab_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
